sobel_window_gen: RTL and testbench

Streaming 3x3 neighbourhood generator that sits directly upstream of the combinational Sobel core. Accepts a raster-order 8-bit grayscale pixel stream, one pixel per enabled clock. Buffers the two previous image lines in on-chip line buffers and presents a registered 3x3 window (p0..p8) with a valid strobe. Its outputs drive the core's pixel inputs directly. Only fully interior windows are emitted, so no border padding is ever produced.

---
 rtl/sobel_window_gen.sv | 124 ++++++++++++
 tb/tb_sobel_window_gen.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/sobel_window_gen.sv
`default_nettype none
// ============================================================================
// Module      : sobel_window_gen
// Description : Raster-stream 3x3 interior window generator with two line
//               buffers, feeding the combinational Sobel core.
// Revision    : 1.0 - initial release
// ============================================================================
module sobel_window_gen #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int COL_W      = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] pix_in,
    input  logic       in_valid,
    input  logic       in_sof,
    output logic [7:0] p0,
    output logic [7:0] p1,
    output logic [7:0] p2,
    output logic [7:0] p3,
    output logic [7:0] p4,
    output logic [7:0] p5,
    output logic [7:0] p6,
    output logic [7:0] p7,
    output logic [7:0] p8,
    output logic       win_valid,
    output logic       win_eof
);

    localparam int               c_aw       = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [COL_W-1:0] c_col_last = COL_W'(IMG_WIDTH - 1);
    localparam logic [COL_W-1:0] c_row_last = COL_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] c_two      = COL_W'(2);
    localparam logic [COL_W-1:0] c_one      = COL_W'(1);

    logic [COL_W-1:0] r_col;
    logic [COL_W-1:0] r_row;
    logic [7:0]       r_lb0 [IMG_WIDTH];
    logic [7:0]       r_lb1 [IMG_WIDTH];
    logic [7:0]       r_win [9];
    logic             r_win_valid;
    logic             r_win_eof;

    logic             w_sof;
    logic [COL_W-1:0] w_col;
    logic [COL_W-1:0] w_row;
    logic [c_aw-1:0]  w_addr;
    logic [7:0]       w_a;
    logic [7:0]       w_b;
    logic             w_col_last;
    logic             w_row_last;
    logic             w_gate;

    // A qualified SOF forces the current pixel to (0,0) regardless of counters.
    assign w_sof      = in_valid && in_sof;
    assign w_col      = w_sof ? '0 : r_col;
    assign w_row      = w_sof ? '0 : r_row;
    assign w_addr     = w_col[c_aw-1:0];
    assign w_a        = r_lb0[w_addr];
    assign w_b        = r_lb1[w_addr];
    assign w_col_last = (w_col == c_col_last);
    assign w_row_last = (w_row == c_row_last);
    assign w_gate     = in_valid && (w_row >= c_two) && (w_col >= c_two);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (in_valid) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : (w_row + c_one);
            end else begin
                r_col <= w_col + c_one;
                r_row <= w_row;
            end
        end
    end

    // Line buffers are deliberately not reset; the row gate hides stale data.
    always_ff @(posedge clk) begin
        if (!rst && in_valid) begin
            r_lb0[w_addr] <= pix_in;
            r_lb1[w_addr] <= w_a;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_win       <= '{default: 8'h00};
            r_win_valid <= 1'b0;
            r_win_eof   <= 1'b0;
        end else begin
            if (in_valid) begin
                r_win[0] <= r_win[1];
                r_win[1] <= r_win[2];
                r_win[2] <= w_b;
                r_win[3] <= r_win[4];
                r_win[4] <= r_win[5];
                r_win[5] <= w_a;
                r_win[6] <= r_win[7];
                r_win[7] <= r_win[8];
                r_win[8] <= pix_in;
            end
            r_win_valid <= w_gate;
            r_win_eof   <= w_gate && w_row_last && w_col_last;
        end
    end

    assign p0        = r_win[0];
    assign p1        = r_win[1];
    assign p2        = r_win[2];
    assign p3        = r_win[3];
    assign p4        = r_win[4];
    assign p5        = r_win[5];
    assign p6        = r_win[6];
    assign p7        = r_win[7];
    assign p8        = r_win[8];
    assign win_valid = r_win_valid;
    assign win_eof   = r_win_eof;

endmodule
`default_nettype wire

// File: tb/tb_sobel_window_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_sobel_window_gen
// Description : Directed self-checking bench for sobel_window_gen (4x4 image).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sobel_window_gen;

    localparam int W = 4;
    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] pix_in;
    logic       in_valid;
    logic       in_sof;
    logic [7:0] p0, p1, p2, p3, p4, p5, p6, p7, p8;
    logic       win_valid;
    logic       win_eof;

    int checks   = 0;
    int failures = 0;
    int windows  = 0;
    int eofs     = 0;

    logic [71:0] obs_win;
    assign obs_win = {p0, p1, p2, p3, p4, p5, p6, p7, p8};

    always #5 clk = ~clk;

    sobel_window_gen #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .COL_W     (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pix_in   (pix_in),
        .in_valid (in_valid),
        .in_sof   (in_sof),
        .p0       (p0),
        .p1       (p1),
        .p2       (p2),
        .p3       (p3),
        .p4       (p4),
        .p5       (p5),
        .p6       (p6),
        .p7       (p7),
        .p8       (p8),
        .win_valid(win_valid),
        .win_eof  (win_eof)
    );

    // Ramp image: pixel (r,c) = off + 16*r + c; window centred at (r,c).
    function automatic logic [71:0] exp_win(input int r, input int c, input logic [7:0] off);
        logic [71:0] v;
        v = '0;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
                v = {v[63:0], 8'(int'(off) + 16 * (r + dr) + (c + dc))};
        return v;
    endfunction

    task automatic chk_flags(input string tag, input logic [1:0] exp);
        checks++;
        assert ({win_valid, win_eof} === exp) else begin
            failures++;
            $error("FAIL %s: valid/eof observed=%b expected=%b", tag, {win_valid, win_eof}, exp);
        end
    endtask

    task automatic chk_win(input string tag, input logic [71:0] exp);
        checks++;
        assert (obs_win === exp) else begin
            failures++;
            $error("FAIL %s: window observed=%h expected=%h", tag, obs_win, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic v, input logic s, input logic [7:0] px);
        rst      = 1'b0;
        in_valid = v;
        in_sof   = s;
        pix_in   = px;
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input logic [7:0] off, input bit sof, input int gap, input int npix);
        int r;
        int c;
        bit ev;
        bit ee;
        for (int i = 0; i < npix; i++) begin
            r  = i / W;
            c  = i % W;
            push(1'b1, sof && (i == 0), 8'(int'(off) + 16 * r + c));
            ev = (r >= 2) && (c >= 2);
            ee = ev && (r == H - 1) && (c == W - 1);
            chk_flags($sformatf("flags off=%h r%0d c%0d", off, r, c), {ev, ee});
            if (ev) begin
                windows++;
                chk_win($sformatf("win off=%h r%0d c%0d", off, r, c), exp_win(r - 1, c - 1, off));
            end
            if (win_eof) eofs++;
            for (int g = 0; g < gap; g++) begin
                push(1'b0, 1'b1, 8'hEE);
                chk_flags($sformatf("idle flags r%0d c%0d g%0d", r, c, g), 2'b00);
                if (ev) chk_win($sformatf("idle hold r%0d c%0d g%0d", r, c, g), exp_win(r - 1, c - 1, off));
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        pix_in   = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk_win("reset window", 72'h0);
        chk_flags("reset flags", 2'b00);

        // Back-to-back ramp frame
        windows = 0; eofs = 0;
        run_frame(8'h00, 1'b1, 0, W * H);
        chk_int("ramp windows", windows, 4);
        chk_int("ramp eofs", eofs, 1);

        // Bubbles: 1,0,0 valid pattern
        windows = 0; eofs = 0;
        run_frame(8'h00, 1'b1, 2, W * H);
        chk_int("bubble windows", windows, 4);
        chk_int("bubble eofs", eofs, 1);

        // Two consecutive frames, second offset by 0x80
        windows = 0; eofs = 0;
        run_frame(8'h00, 1'b1, 0, W * H);
        run_frame(8'h80, 1'b1, 0, W * H);
        chk_int("two-frame windows", windows, 8);
        chk_int("two-frame eofs", eofs, 2);

        // Reset after pixel (2,1); pixel offered during reset is dropped
        run_frame(8'h00, 1'b1, 0, 10);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_sof   = 1'b0;
        pix_in   = 8'h55;
        @(posedge clk);
        #1;
        chk_win("mid reset window", 72'h0);
        chk_flags("mid reset flags", 2'b00);
        windows = 0; eofs = 0;
        run_frame(8'h00, 1'b0, 0, W * H);
        chk_int("post-reset windows", windows, 4);
        chk_int("post-reset eofs", eofs, 1);

        // SOF resync at pixel (1,2) of an old frame
        windows = 0; eofs = 0;
        run_frame(8'h00, 1'b1, 0, 6);
        run_frame(8'h30, 1'b1, 0, W * H);
        chk_int("resync windows", windows, 4);
        chk_int("resync eofs", eofs, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
